uart_tx: RTL and testbench
==========================

# uart_tx

Transmit half of the serial-to-SPI bridge's UART link. Accepts bytes from the parallel side through a one-entry holding buffer. Requests the line with RTS and waits for CTS from the far-end receiver. Shifts each byte out on TX_D as an 8N1 frame (optionally 8E1) at a fixed integer baud divisor from the system clock.

## Interface
- BAUD_DIV, default 5208: system clocks per bit (50 MHz / 9600 baud); legal range 2..65535.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- BYTEIN  in  8  byte to transmit; sampled only when load=1 and ready=1.
- load  in  1  one-cycle write strobe from the parallel side.
- ready  out  1  holding buffer empty; load is accepted this cycle.
- busy  out  1  FSM not in IDLE, or holding buffer full.
- done  out  1  one-cycle pulse on the final clock of each stop bit.
- RTS  out  1  request to send; high while a byte waits for or occupies the line.
- CTS  in  1  clear to send from the receiver; treated as synchronous (external 2-flop synchronizer).
- TX_D  out  1  serial data; idles high.

## Operation
- Reset values: TX_D=1, RTS=0, ready=1, busy=0, done=0; FSM=IDLE, baud counter=0, bit index=0, holding buffer empty.
- Holding buffer: load && ready on edge N latches BYTEIN, and ready=0 from N+1. load while ready=0 is ignored; the byte is dropped and there is no error flag. The buffer is freed on the REQ→START transition, so ready=1 during START and a second byte can be queued while the first frame is on the line.
- States:
  - IDLE: TX_D=1, RTS=0. If buffer full → REQ.
  - REQ: RTS=1, TX_D=1. Waits indefinitely for CTS=1. On the edge CTS is sampled high: copy buffer to shift register, clear buffer → START.
  - START: TX_D=0 for BAUD_DIV clocks → DATA.
  - DATA: TX_D=shift[0], 8 bits LSB first, each BAUD_DIV clocks, bit index 0..7. After bit 7 → PARITY if configured, else STOP.
  - PARITY: TX_D = XOR of the 8 data bits (even parity) for BAUD_DIV clocks → STOP.
  - STOP: TX_D=1 for BAUD_DIV clocks; done=1 on its last clock. Then → REQ if buffer full (RTS stays high), else → IDLE (RTS drops).
- RTS is high in REQ, START, DATA, PARITY and STOP.
- CTS is checked only in REQ. CTS falling mid-frame does not abort; the frame completes, and the next frame waits in REQ.
- Baud counter: 16-bit. Resets to 0 on every state entry and counts to BAUD_DIV-1, at which the bit ends. There is no drift across a frame.
- load on the same edge the buffer empties (REQ→START) is not accepted, because ready was 0 that cycle. The byte is accepted on the next cycle.
- rst mid-frame: all state returns to reset values on the next edge. TX_D returns high, and the buffered byte is discarded.

## Timing
- Load on edge N into an idle block: FSM in REQ and RTS=1 from N+1.
- With CTS already high, CTS is sampled on edge N+1. START (TX_D=0) is visible from N+2.
- Frame length: 10·BAUD_DIV clocks (11·BAUD_DIV with parity), from first START clock to last STOP clock inclusive.
- Back-to-back frames with CTS held high: next START begins on the clock after the last STOP clock plus one REQ cycle. The inter-frame idle-high gap is exactly 1 clock.
- done: single clock, coincident with the last STOP clock.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state compiled in; even parity bit inserted between bit 7 and stop; frame is 11 bits.
- UART_TX_PARITY_EN undefined: PARITY state and XOR logic absent; 8N1 frame of 10 bits.

## Test plan
- Reset: hold rst 3 cycles mid-frame (BAUD_DIV=4) → next cycle TX_D=1, RTS=0, ready=1, busy=0; no further TX_D transitions.
- Single byte 0xA5, CTS=1, BAUD_DIV=4 → RTS high the cycle after load. TX_D sequence per 4 clocks: 0,1,0,1,0,0,1,0,1,1 (no parity). done pulses once; RTS low after.
- CTS stalled: load 0x3C with CTS=0 for 20 cycles → RTS=1 and TX_D=1 throughout. CTS=1 → start bit two edges later.
- Back-to-back: load 0x01, then load 0x80 when ready returns → two contiguous frames. RTS stays high between them, with a 1-clock idle gap. A load while ready=0 is dropped.
- CTS drop mid-frame: deassert CTS during data bit 3 → frame completes unchanged. The next queued byte waits in REQ.
- With UART_TX_PARITY_EN, byte 0x07 → parity bit 1, 11-bit frame of 44 clocks at BAUD_DIV=4. Byte 0x03 → parity bit 0.

Source files
------------

// File: rtl/uart_tx_if.sv
// Parallel-side byte handshake for uart_tx.
// The host writes BYTEIN with a load strobe when ready is high.
interface uart_tx_if;
  logic [7:0] BYTEIN;
  logic       load;
  logic       ready;
  logic       busy;
  logic       done;

  modport master (
    output BYTEIN, load,
    input  ready, busy, done
  );

  modport slave (
    input  BYTEIN, load,
    output ready, busy, done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter with RTS/CTS flow control and a one-byte holding buffer.
// Define UART_TX_PARITY_EN to add an even parity bit (8E1 instead of 8N1).
module uart_tx #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus,
  output logic      RTS,
  input  logic      CTS,
  output logic      TX_D
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  hold_q;
  logic        full_q;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
`endif

  logic accept, take, timed, bit_end;
  logic line, rts_w, done_w;

  assign accept  = bus.load && !full_q;
  assign bit_end = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    take    = 1'b0;
    timed   = 1'b0;
    line    = 1'b1;
    rts_w   = 1'b1;
    done_w  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rts_w = 1'b0;
        if (full_q || accept) state_d = S_REQ;
      end
      S_REQ: begin
        if (CTS) begin
          take    = 1'b1;
          shreg_d = hold_q;
          state_d = S_START;
        end
      end
      S_START: begin
        timed = 1'b1;
        line  = 1'b0;
        if (bit_end) begin
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        timed = 1'b1;
        line  = shreg_q[0];
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        timed = 1'b1;
        line  = par_q;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        timed = 1'b1;
        if (bit_end) begin
          done_w  = 1'b1;
          state_d = (full_q || accept) ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Counter restarts at every bit boundary, so a frame never drifts.
    cnt_d = (timed && !bit_end) ? cnt_q + 16'd1 : 16'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 8'd0;
      full_q <= 1'b0;
    end else if (accept) begin
      hold_q <= bus.BYTEIN;
      full_q <= 1'b1;
    end else if (take) begin
      full_q <= 1'b0;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)       par_q <= 1'b0;
    else if (take) par_q <= ^hold_q;
  end
`endif

  assign TX_D      = line;
  assign RTS       = rts_w;
  assign bus.done  = done_w;
  assign bus.ready = !full_q;
  assign bus.busy  = (state_q != S_IDLE) || full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at BAUD_DIV=4.
// A monitor decodes frames off TX_D and checks them against queued bytes.
module tb_uart_tx;
  localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * BD;
  localparam int NF    = 8;
`else
  localparam int FRAME = 10 * BD;
  localparam int NF    = 6;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic CTS = 1'b0;
  logic RTS, TX_D;

  uart_tx_if bus();

  uart_tx #(.BAUD_DIV(BD)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .RTS  (RTS),
    .CTS  (CTS),
    .TX_D (TX_D)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int frames = 0;
  bit mon_en = 1'b0;
  logic [8:0] expq[$];
  int starts[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: decode each frame, sampling one clock into every bit.
  initial begin : mon
    logic prev;
    logic [7:0] b;
    logic p;
    logic [8:0] e;
    prev = 1'b1;
    b = 8'd0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && prev && !TX_D) begin
        starts.push_back(cyc);
        @(negedge clk);
        check("start_bit", {31'd0, TX_D}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = TX_D;
        end
        p = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (BD) @(negedge clk);
        p = TX_D;
`endif
        repeat (BD) @(negedge clk);
        check("stop_bit", {31'd0, TX_D}, 32'd1);
        repeat (BD - 2) @(negedge clk);
        check("done_at_stop_end", {31'd0, bus.done}, 32'd1);
        frames++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame got %0h want none", b);
        end else begin
          e = expq.pop_front();
          check("byte", {24'd0, b}, {24'd0, e[7:0]});
`ifdef UART_TX_PARITY_EN
          check("parity", {31'd0, p}, {31'd0, e[8]});
`endif
        end
        prev = 1'b1;
      end else begin
        prev = TX_D;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] b);
    bus.BYTEIN = b;
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
  endtask

  task automatic wait_idle(input int n);
    int k;
    k = 0;
    while (bus.busy && k < n) begin
      tick();
      k++;
    end
    check("idle_in_time", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_gap(input string name);
    int n;
    n = starts.size();
    if (n >= 2) begin
      check(name, starts[n-1] - starts[n-2], FRAME + 1);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s got %0d frames want 2", name, n);
    end
  endtask

  initial begin : stim
    int bad;
    int d0;
    int k;
    bus.load   = 1'b0;
    bus.BYTEIN = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_txd", {31'd0, TX_D}, 32'd1);
    check("rst_rts", {31'd0, RTS}, 32'd0);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);

    // Reset in the middle of a frame.
    CTS = 1'b1;
    load(8'hFF);
    repeat (14) tick();
    check("midframe_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst1_txd", {31'd0, TX_D}, 32'd1);
    check("rst1_rts", {31'd0, RTS}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst3_ready", {31'd0, bus.ready}, 32'd1);
    check("rst3_busy", {31'd0, bus.busy}, 32'd0);
    bad = 0;
    repeat (50) begin
      tick();
      if (TX_D !== 1'b1 || RTS !== 1'b0) bad++;
    end
    check("quiet_after_rst", bad, 0);
    mon_en = 1'b1;

    // Single byte 0xA5.
    d0 = done_cnt;
    expq.push_back({1'b0, 8'hA5});
    load(8'hA5);
    check("rts_after_load", {31'd0, RTS}, 32'd1);
    check("ready_after_load", {31'd0, bus.ready}, 32'd0);
    check("txd_in_req", {31'd0, TX_D}, 32'd1);
    tick();
    check("start_after_req", {31'd0, TX_D}, 32'd0);
    check("ready_in_start", {31'd0, bus.ready}, 32'd1);
    wait_idle(100);
    check("rts_low_after", {31'd0, RTS}, 32'd0);
    check("one_done", done_cnt - d0, 1);

    // CTS held low stalls in REQ.
    CTS = 1'b0;
    expq.push_back({1'b0, 8'h3C});
    load(8'h3C);
    bad = 0;
    repeat (20) begin
      if (RTS !== 1'b1 || TX_D !== 1'b1) bad++;
      tick();
    end
    check("cts_stall", bad, 0);
    CTS = 1'b1;
    tick();
    check("start_after_cts", {31'd0, TX_D}, 32'd0);
    wait_idle(100);

    // Back-to-back with a dropped load while the buffer is full.
    expq.push_back({1'b1, 8'h01});
    load(8'h01);
    check("ready_low", {31'd0, bus.ready}, 32'd0);
    load(8'hEE);
    check("ready_back", {31'd0, bus.ready}, 32'd1);
    expq.push_back({1'b1, 8'h80});
    load(8'h80);
    bad = 0;
    k = 0;
    while (bus.busy && k < 200) begin
      if (RTS !== 1'b1) bad++;
      tick();
      k++;
    end
    check("b2b_idle", {31'd0, bus.busy}, 32'd0);
    check("b2b_rts_held", bad, 0);
    check_gap("b2b_gap");

    // CTS drops during data bit 3 of the first frame.
    expq.push_back({1'b0, 8'h5A});
    load(8'h5A);
    tick();
    check("cd_start", {31'd0, TX_D}, 32'd0);
    expq.push_back({1'b0, 8'hC3});
    load(8'hC3);
    repeat (15) tick();
    CTS = 1'b0;
    k = 0;
    while (!bus.done && k < 100) begin
      tick();
      k++;
    end
    check("cd_done_seen", {31'd0, bus.done}, 32'd1);
    tick();
    bad = 0;
    repeat (20) begin
      if (RTS !== 1'b1 || TX_D !== 1'b1) bad++;
      tick();
    end
    check("cd_wait_req", bad, 0);
    check("cd_held", {31'd0, bus.ready}, 32'd0);
    CTS = 1'b1;
    wait_idle(200);

`ifdef UART_TX_PARITY_EN
    expq.push_back({1'b1, 8'h07});
    load(8'h07);
    tick();
    expq.push_back({1'b0, 8'h03});
    load(8'h03);
    wait_idle(200);
    check_gap("par_gap");
`endif

    repeat (5) tick();
    check("queue_empty", expq.size(), 0);
    check("frames", frames, NF);
    check("done_count", done_cnt, NF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
